// File: rtl/ldpc_info_blk_packer.sv
// Packs IN_W-bit input words into MAX_Z-bit LDPC information sub-blocks of a
// per-codeword lifting size Z, with a one-deep output register and backpressure.
module ldpc_info_blk_packer #(
    parameter int MAX_Z            = 81,
    parameter int NUM_Z            = 3,
    parameter int Z_VALUES [NUM_Z] = '{27, 54, 81},
    parameter int NUM_INFO_BLKS    = 20,
    parameter int IN_W             = 9
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_Z-1:0]                 cfg_z_sel,
    input  logic                             s_valid,
    output logic                             s_ready,
    input  logic [IN_W-1:0]                  s_data,
    output logic                             m_valid,
    input  logic                             m_ready,
    output logic [MAX_Z-1:0]                 m_data,
    output logic [$clog2(NUM_INFO_BLKS)-1:0] m_blk_idx,
    output logic                             m_first,
    output logic                             m_last,
    output logic [NUM_Z-1:0]                 m_z_sel,
    output logic                             cfg_err
);
    localparam int WPB_MAX = MAX_Z / IN_W;
    localparam int WW      = $clog2(WPB_MAX + 1);
    localparam int BW      = $clog2(NUM_INFO_BLKS);
    localparam logic [BW-1:0] LAST_BLK = BW'(NUM_INFO_BLKS - 1);

    typedef enum logic [1:0] {IDLE, FILL, STALL} state_t;
    state_t r_state, w_state_nxt;

    logic [NUM_Z-1:0] r_zsel;
    logic [WW-1:0]    r_wpb, r_wcnt;
    logic [BW-1:0]    r_bcnt;
    logic [MAX_Z-1:0] r_fill;
    logic             r_mvalid, r_mfirst, r_mlast, r_cfg_err;
    logic [MAX_Z-1:0] r_mdata;
    logic [BW-1:0]    r_midx;
    logic [NUM_Z-1:0] r_mzsel;

    logic             w_cfg_ok, w_idle, w_acc, w_lastw, w_out_free;
    logic             w_xfer_fill, w_xfer_stall, w_load, w_ld_last;
    logic [WW-1:0]    w_cfg_wpb, w_w, w_wpb;
    logic [BW-1:0]    w_blk, w_ld_blk, w_blk_nxt;
    logic [NUM_Z-1:0] w_zsel, w_ld_zsel;
    logic [MAX_Z-1:0] w_fill_wr, w_ld_data;

    always_comb begin
        w_cfg_ok  = (cfg_z_sel != '0) && ((cfg_z_sel & (cfg_z_sel - NUM_Z'(1))) == '0);
        w_cfg_wpb = '0;
        for (int i = 0; i < NUM_Z; i++)
            if (cfg_z_sel[i]) w_cfg_wpb = WW'(Z_VALUES[i] / IN_W);
    end

    // In IDLE the accepted word is word 0 of block 0 under the live cfg_z_sel.
    assign w_idle  = (r_state == IDLE);
    assign s_ready = !rst && ((r_state == FILL) || (w_idle && w_cfg_ok));
    assign w_acc   = s_valid && s_ready;
    assign w_w     = w_idle ? '0 : r_wcnt;
    assign w_wpb   = w_idle ? w_cfg_wpb : r_wpb;
    assign w_blk   = w_idle ? '0 : r_bcnt;
    assign w_zsel  = w_idle ? cfg_z_sel : r_zsel;
    assign w_lastw = ((w_w + WW'(1)) == w_wpb);

    // Word 0 clears the fill so bits at and above Z stay zero.
    always_comb begin
        w_fill_wr = (w_w == '0) ? '0 : r_fill;
        for (int k = 0; k < WPB_MAX; k++)
            if (w_w == WW'(k)) w_fill_wr[k*IN_W +: IN_W] = s_data;
    end

    assign w_out_free   = !r_mvalid || m_ready;
    assign w_xfer_fill  = w_acc && w_lastw && w_out_free;
    assign w_xfer_stall = (r_state == STALL) && m_ready;
    assign w_load       = w_xfer_fill || w_xfer_stall;
    assign w_ld_data    = w_xfer_stall ? r_fill : w_fill_wr;
    assign w_ld_blk     = w_xfer_stall ? r_bcnt : w_blk;
    assign w_ld_zsel    = w_xfer_stall ? r_zsel : w_zsel;
    assign w_ld_last    = (w_ld_blk == LAST_BLK);
    assign w_blk_nxt    = w_ld_last ? '0 : w_ld_blk + BW'(1);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE, FILL: begin
                if (w_acc) begin
                    if (!w_lastw)        w_state_nxt = FILL;
                    else if (w_out_free) w_state_nxt = w_ld_last ? IDLE : FILL;
                    else                 w_state_nxt = STALL;
                end
            end
            STALL:   if (m_ready) w_state_nxt = w_ld_last ? IDLE : FILL;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_zsel <= '0;
            r_wpb  <= '0;
            r_wcnt <= '0;
            r_bcnt <= '0;
            r_fill <= '0;
        end else begin
            if (w_acc) begin
                if (w_idle) begin
                    r_zsel <= cfg_z_sel;
                    r_wpb  <= w_cfg_wpb;
                end
                r_fill <= w_fill_wr;
                if (w_lastw) begin
                    r_wcnt <= '0;
                    r_bcnt <= w_out_free ? w_blk_nxt : w_blk;
                end else begin
                    r_wcnt <= w_w + WW'(1);
                    r_bcnt <= w_blk;
                end
            end
            if (w_xfer_stall) r_bcnt <= w_blk_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mvalid <= 1'b0;
            r_mdata  <= '0;
            r_midx   <= '0;
            r_mfirst <= 1'b0;
            r_mlast  <= 1'b0;
            r_mzsel  <= '0;
        end else if (w_load) begin
            r_mvalid <= 1'b1;
            r_mdata  <= w_ld_data;
            r_midx   <= w_ld_blk;
            r_mfirst <= (w_ld_blk == '0);
            r_mlast  <= w_ld_last;
            r_mzsel  <= w_ld_zsel;
        end else if (m_ready) begin
            r_mvalid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_cfg_err <= 1'b0;
        else     r_cfg_err <= w_idle && s_valid && !w_cfg_ok;
    end

    assign m_valid   = r_mvalid;
    assign m_data    = r_mdata;
    assign m_blk_idx = r_midx;
    assign m_first   = r_mfirst;
    assign m_last    = r_mlast;
    assign m_z_sel   = r_mzsel;
    assign cfg_err   = r_cfg_err;
endmodule

// File: tb/tb_ldpc_info_blk_packer.sv
// Directed plus random bench for ldpc_info_blk_packer with a packing-model scoreboard.
module tb_ldpc_info_blk_packer;
    logic        clk, rst;
    logic [2:0]  cfg_z_sel;
    logic        s_valid, s_ready;
    logic [8:0]  s_data;
    logic        m_valid, m_ready;
    logic [80:0] m_data;
    logic [4:0]  m_blk_idx;
    logic        m_first, m_last, cfg_err;
    logic [2:0]  m_z_sel;

    ldpc_info_blk_packer dut (
        .clk(clk), .rst(rst), .cfg_z_sel(cfg_z_sel),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_blk_idx(m_blk_idx), .m_first(m_first), .m_last(m_last),
        .m_z_sel(m_z_sel), .cfg_err(cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [80:0] d;
        logic [4:0]  idx;
        logic [2:0]  z;
    } exp_t;
    exp_t q[$];

    int n_tests = 0, n_fail = 0;
    int mw = 0, mb = 0, mwpb = 0, cw_done = 0, hs_cnt = 0, nrdy_low = 0;
    logic [2:0]  mz;
    logic [80:0] mfill;
    logic        held = 0, pushed_prev = 0, lat_chk = 0;
    logic [80:0] h_data;
    logic [4:0]  h_idx;
    logic [2:0]  h_z;
    logic        h_first, h_last;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_word(input logic [8:0] d, output logic pushed);
        exp_t e;
        pushed = 1'b0;
        if (mw == 0 && mb == 0) begin
            mz = cfg_z_sel;
            case (mz)
                3'b001:  mwpb = 3;
                3'b010:  mwpb = 6;
                default: mwpb = 9;
            endcase
        end
        if (mw == 0) mfill = '0;
        mfill[mw*9 +: 9] = d;
        mw++;
        if (mw == mwpb) begin
            e.d = mfill; e.idx = 5'(mb); e.z = mz;
            q.push_back(e);
            mw = 0;
            if (mb == 19) begin mb = 0; cw_done++; end
            else mb++;
            pushed = 1'b1;
        end
    endtask

    // One clock: sample at the falling edge, then settle just after the rising edge.
    task automatic tick();
        exp_t e;
        logic pushed;
        @(negedge clk);
        pushed = 1'b0;
        if (held) begin
            chk("hold_valid", m_valid, 1'b1);
            chk("hold_data", m_data, h_data);
            chk("hold_idx", {m_blk_idx, m_z_sel, m_first, m_last}, {h_idx, h_z, h_first, h_last});
        end
        if (m_valid && m_ready) begin
            hs_cnt++;
            n_tests++;
            assert (q.size() != 0) else begin
                n_fail++;
                $error("FAIL sb_underflow: observed idx %0d expected no output", m_blk_idx);
            end
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("out_data", m_data, e.d);
                chk("out_idx", m_blk_idx, e.idx);
                chk("out_zsel", m_z_sel, e.z);
                chk("out_first_last", {m_first, m_last}, {e.idx == 5'd0, e.idx == 5'd19});
            end
        end
        if (lat_chk && pushed_prev) chk("latency", m_valid, 1'b1);
        if (s_valid && !s_ready) nrdy_low++;
        if (s_valid && s_ready) model_word(s_data, pushed);
        held = m_valid && !m_ready;
        h_data = m_data; h_idx = m_blk_idx; h_z = m_z_sel; h_first = m_first; h_last = m_last;
        pushed_prev = pushed;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        q.delete();
        mw = 0; mb = 0; held = 0; pushed_prev = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1; s_valid = 1'b0;
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int cyc;
        rst = 1'b1; cfg_z_sel = 3'b001; s_valid = 1'b1; s_data = 9'h1ff; m_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_outs", {m_valid, cfg_err, m_first, m_last, s_ready}, 5'b0);
        chk("rst_idx_z", {m_blk_idx, m_z_sel}, 8'b0);
        chk("rst_data", m_data, 81'b0);
        s_valid = 1'b0;
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // Z=27 at full rate: 60 words, 20 blocks, no bubbles.
        cfg_z_sel = 3'b001; m_ready = 1'b1; hs_cnt = 0; nrdy_low = 0; lat_chk = 1;
        for (int k = 0; k < 60; k++) begin
            s_valid = 1'b1; s_data = 9'(k);
            tick();
        end
        s_valid = 1'b0;
        repeat (3) tick();
        lat_chk = 0;
        chk("t1_blocks", hs_cnt, 20);
        chk("t1_no_bubble", nrdy_low, 0);
        chk("t1_sb_empty", q.size(), 0);

        // Z=81 with downstream stalled from the start.
        do_reset();
        cfg_z_sel = 3'b100; m_ready = 1'b0; s_valid = 1'b1;
        for (int k = 0; k < 9; k++) begin s_data = 9'($urandom); tick(); end
        chk("t2_blk0_held", {m_valid, m_blk_idx, s_ready}, {1'b1, 5'd0, 1'b1});
        for (int k = 0; k < 9; k++) begin s_data = 9'($urandom); tick(); end
        chk("t2_stall", {s_ready, m_valid, m_blk_idx}, {1'b0, 1'b1, 5'd0});
        repeat (2) tick();
        chk("t2_stall_kept", s_ready, 1'b0);
        m_ready = 1'b1;
        tick();
        chk("t2_blk1", {m_valid, m_blk_idx, s_ready}, {1'b1, 5'd1, 1'b1});
        s_valid = 1'b0;
        tick();
        chk("t2_drained", m_valid, 1'b0);

        // Invalid one-hot select in IDLE, then Z=54 codeword followed by Z=27.
        do_reset();
        cfg_z_sel = 3'b011; s_valid = 1'b1; m_ready = 1'b1;
        #1 chk("t3_bad_ready", s_ready, 1'b0);
        tick();
        chk("t3_cfg_err", {cfg_err, m_valid}, 2'b10);
        s_valid = 1'b0;
        tick();
        chk("t3_cfg_err_clr", cfg_err, 1'b0);
        cfg_z_sel = 3'b010; s_valid = 1'b1; s_data = 9'h0a5;
        #1 chk("t3_good_ready", s_ready, 1'b1);
        hs_cnt = 0; nrdy_low = 0;
        tick();
        chk("t3_no_err", cfg_err, 1'b0);
        for (int k = 1; k < 5; k++) begin s_data = 9'($urandom); tick(); end
        chk("t3_wpb_not_yet", m_valid, 1'b0);
        s_data = 9'($urandom); tick();
        chk("t3_wpb6", {m_valid, m_blk_idx, m_z_sel}, {1'b1, 5'd0, 3'b010});
        for (int k = 6; k < 120; k++) begin
            if (k == 40) cfg_z_sel = 3'b100;
            if (k == 90) cfg_z_sel = 3'b001;
            s_data = 9'($urandom); tick();
        end
        chk("t4_cw2_start_ready", s_ready, 1'b1);
        for (int k = 0; k < 60; k++) begin s_data = 9'($urandom); tick(); end
        s_valid = 1'b0;
        repeat (3) tick();
        chk("t4_blocks", hs_cnt, 40);
        chk("t4_no_bubble", nrdy_low, 0);
        chk("t4_sb_empty", q.size(), 0);

        // Reset in the middle of block 7 at Z=81.
        do_reset();
        cfg_z_sel = 3'b100; m_ready = 1'b1; s_valid = 1'b1;
        for (int k = 0; k < 67; k++) begin s_data = 9'($urandom); tick(); end
        rst = 1'b1;
        #1;
        chk("t5_rst_outs", {m_valid, cfg_err, m_first, m_last, s_ready, m_blk_idx, m_z_sel}, 13'b0);
        chk("t5_rst_data", m_data, 81'b0);
        clear_model();
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 9; k++) begin s_data = 9'h100 + 9'(k); tick(); end
        chk("t5_restart", {m_valid, m_blk_idx, m_first}, {1'b1, 5'd0, 1'b1});
        s_valid = 1'b0;
        tick();
        chk("t5_sb_empty", q.size(), 0);

        // Random handshakes over 100 codewords; cfg noise outside codeword starts.
        do_reset();
        cw_done = 0; cyc = 0;
        while (cw_done < 100 && cyc < 80000) begin
            if (mw == 0 && mb == 0) cfg_z_sel = 3'b001 << $urandom_range(0, 2);
            else                    cfg_z_sel = 3'($urandom_range(0, 7));
            s_valid = ($urandom_range(0, 3) != 0);
            s_data  = 9'($urandom);
            m_ready = ($urandom_range(0, 3) != 0);
            tick();
            cyc++;
        end
        chk("t6_codewords", cw_done, 100);
        s_valid = 1'b0; m_ready = 1'b1; cyc = 0;
        while (q.size() != 0 && cyc < 20) begin tick(); cyc++; end
        tick();
        chk("t6_sb_empty", q.size(), 0);
        chk("t6_idle", m_valid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
